// File: rtl/pixel_plot_sink.sv
// Pixel-write sink: buffers drawer pixels in a small FIFO, clips off-screen ones, drives the VGA plot port.
// Latency: a pixel accepted at edge N is plotted during the cycle after edge N+1; PixelReady falls only when the FIFO is full.
module pixel_plot_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int COLOUR_W   = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [7:0]          XIn,
  input  logic [6:0]          YIn,
  input  logic [COLOUR_W-1:0] ColourIn,
  input  logic                LastIn,
  input  logic                PixelValid,
  output logic                PixelReady,
  input  logic                Hold,
  output logic [7:0]          PlotX,
  output logic [6:0]          PlotY,
  output logic [COLOUR_W-1:0] PlotColour,
  output logic                Plot,
  output logic                DoneDrawing,
  output logic [7:0]          ClipCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  SW9  = 9'(SCREEN_W);
  localparam logic [7:0]  SH8  = 8'(SCREEN_H);

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                last;
  } pix_t;

  typedef enum logic [1:0] {IDLE, DRAIN, PAUSED} state_t;

  pix_t                mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [PW:0]         occ_q, occ_d;
  state_t              state_q, state_d;
  logic [7:0]          plot_x_q, plot_x_d;
  logic [6:0]          plot_y_q, plot_y_d;
  logic [COLOUR_W-1:0] plot_c_q, plot_c_d;
  logic                plot_q, plot_d, done_q, done_d;
  logic [7:0]          clip_q, clip_d;

  logic push, pop, in_range;
  pix_t head, pix_in;

  assign PixelReady = (occ_q != FULL);
  assign push       = PixelValid && PixelReady;
  assign pop        = (occ_q != '0) && !Hold;
  assign head       = mem_q[rd_ptr_q];
  assign pix_in     = '{x: XIn, y: YIn, colour: ColourIn, last: LastIn};
  // Zero-extended compares so out-of-range codes like X=255 clip rather than wrap.
  assign in_range   = ({1'b0, head.x} < SW9) && ({1'b0, head.y} < SH8);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    plot_x_d = plot_x_q;
    plot_y_d = plot_y_q;
    plot_c_d = plot_c_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    clip_d   = clip_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      done_d = head.last;
      if (in_range) begin
        plot_d   = 1'b1;
        plot_x_d = head.x;
        plot_y_d = head.y;
        plot_c_d = head.colour;
      end else if (clip_q != 8'hFF) begin
        clip_d = clip_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = DRAIN;
      DRAIN: begin
        if (Hold)                                    state_d = PAUSED;
        else if (pop && occ_q == (PW+1)'(1) && !push) state_d = IDLE;
      end
      PAUSED:  if (!Hold) state_d = (occ_d != '0) ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= pix_in;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= IDLE;
      plot_x_q <= '0;
      plot_y_q <= '0;
      plot_c_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      clip_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
      plot_c_q <= plot_c_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      clip_q   <= clip_d;
    end
  end

  assign PlotX       = plot_x_q;
  assign PlotY       = plot_y_q;
  assign PlotColour  = plot_c_q;
  assign Plot        = plot_q;
  assign DoneDrawing = done_q;
  assign ClipCount   = clip_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboarded bench for pixel_plot_sink: the model predicts the observable plot/done events per accepted pixel.
module tb_pixel_plot_sink;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] XIn = '0;
  logic [6:0] YIn = '0;
  logic [2:0] ColourIn = '0;
  logic       LastIn = 1'b0;
  logic       PixelValid = 1'b0;
  logic       PixelReady;
  logic       Hold = 1'b0;
  logic [7:0] PlotX;
  logic [6:0] PlotY;
  logic [2:0] PlotColour;
  logic       Plot;
  logic       DoneDrawing;
  logic [7:0] ClipCount;

  pixel_plot_sink #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .XIn(XIn), .YIn(YIn), .ColourIn(ColourIn),
    .LastIn(LastIn), .PixelValid(PixelValid), .PixelReady(PixelReady), .Hold(Hold),
    .PlotX(PlotX), .PlotY(PlotY), .PlotColour(PlotColour), .Plot(Plot),
    .DoneDrawing(DoneDrawing), .ClipCount(ClipCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         clip_cnt = 0;
  logic [7:0] lx = '0;
  logic [6:0] ly = '0;
  logic [2:0] lc = '0;
  bit         rnd_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Every accepted pixel is retired in order; only plotted or Last pixels are visible on the outputs.
  function automatic void model_push(input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] c, input logic l);
    bit inr;
    ev_t e;
    inr = (int'(x) < 160) && (int'(y) < 120);
    if (!inr) clip_cnt++;
    if (inr) begin
      lx = x; ly = y; lc = c;
    end
    if (inr || l) begin
      e = '{plot: inr, x: lx, y: ly, c: lc, done: l};
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [31:0] exp_clip();
    return (clip_cnt > 255) ? 32'd255 : 32'(clip_cnt);
  endfunction

  always @(negedge Clock) begin
    if (Reset === 1'b1 && (Plot === 1'b1 || DoneDrawing === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {Plot, DoneDrawing}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("plot_event", {12'd0, Plot, PlotX, PlotY, PlotColour, DoneDrawing}, {12'd0, e});
      end
    end
  end

  always @(negedge Clock) begin
    if (rnd_phase) Hold = ($urandom_range(0, 2) == 0);
  end

  // Starts and ends on a falling edge.
  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      input logic l, output int stalls);
    bit accepted = 0;
    stalls = 0;
    XIn = x; YIn = y; ColourIn = c; LastIn = l; PixelValid = 1'b1;
    while (!accepted && stalls < 100) begin
      if (PixelReady === 1'b1) begin
        @(posedge Clock);
        model_push(x, y, c, l);
        accepted = 1;
      end else begin
        @(posedge Clock);
        stalls++;
      end
      @(negedge Clock);
    end
    PixelValid = 1'b0;
    if (!accepted) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    Hold = 1'b0;
    repeat (12) @(negedge Clock);
  endtask

  initial begin
    int st, total_st;
    #1;
    chk("rst_plot", Plot, 0);
    chk("rst_plotx", PlotX, 0);
    chk("rst_done", DoneDrawing, 0);
    chk("rst_clip", ClipCount, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_ready", PixelReady, 1);

    // Single pixel latency.
    send(8'd10, 7'd20, 3'd5, 1'b1, st);
    chk("no_bypass", Plot, 0);
    @(negedge Clock);
    chk("lat_plot", {Plot, PlotX, PlotY, PlotColour, DoneDrawing}, {1'b1, 8'd10, 7'd20, 3'd5, 1'b1});
    @(negedge Clock);
    chk("lat_after", {Plot, DoneDrawing}, 0);

    // Fill under Hold, fifth pixel waits.
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(30 + i), 7'(40 + i), 3'(i), 1'b0, st);
    chk("full_ready", PixelReady, 0);
    XIn = 8'd50; YIn = 7'd60; ColourIn = 3'd7; LastIn = 1'b1; PixelValid = 1'b1;
    repeat (2) @(negedge Clock);
    chk("held_ready", PixelReady, 0);
    chk("held_plot", Plot, 0);
    Hold = 1'b0;
    @(negedge Clock);
    chk("ready_after_pop", PixelReady, 1);
    chk("plot_after_pop", Plot, 1);
    send(8'd50, 7'd60, 3'd7, 1'b1, st);
    drain();
    chk("q_empty_hold", exp_q.size(), 0);

    // Clip boundaries.
    send(8'd159, 7'd119, 3'd1, 1'b0, st);
    send(8'd160, 7'd0,   3'd2, 1'b0, st);
    send(8'd0,   7'd120, 3'd3, 1'b0, st);
    send(8'd255, 7'd127, 3'd4, 1'b1, st);
    drain();
    chk("clip_count3", ClipCount, exp_clip());

    // Continuous stream, never stalls.
    total_st = 0;
    for (int i = 0; i < 50; i++) begin
      send(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom),
           1'($urandom), st);
      total_st += st;
    end
    chk("stream_stalls", total_st, 0);
    drain();
    chk("q_empty_stream", exp_q.size(), 0);

    // Random pixels with random Hold.
    rnd_phase = 1;
    for (int i = 0; i < 60; i++)
      send(8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0), st);
    rnd_phase = 0;
    repeat (2) @(negedge Clock);
    drain();
    chk("clip_random", ClipCount, exp_clip());
    chk("q_empty_random", exp_q.size(), 0);

    // Saturation.
    for (int i = 0; i < 300; i++) send(8'd200, 7'($urandom), 3'($urandom), 1'b0, st);
    drain();
    chk("clip_sat", ClipCount, exp_clip());

    // Reset with buffered pixels.
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(70 + i), 7'(10 + i), 3'(i + 1), 1'b1, st);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_outs", {Plot, PlotX, PlotY, PlotColour, DoneDrawing}, 0);
    chk("mid_rst_clip", ClipCount, 0);
    chk("mid_rst_ready", PixelReady, 1);
    exp_q.delete();
    clip_cnt = 0; lx = '0; ly = '0; lc = '0;
    #1 Reset = 1'b1;
    @(negedge Clock);
    drain();
    chk("post_rst_ready", PixelReady, 1);
    chk("post_rst_plot", Plot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
